// File: rtl/syn_ucnt_timer.sv
// Synchronous up-counting interval timer: toggle-chain counter with run/done FSM,
// compare/terminal-count pulse and one-shot/periodic modes. Define SYNUCNT_DIR_EN for DNL.
module syn_ucnt_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             cll,
  input  logic             ldl,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] cmp,
  input  logic             go,
  input  logic             ci,
  input  logic             period,
`ifdef SYNUCNT_DIR_EN
  input  logic             dnl,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             co,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] reload;
  logic             tc_q, tc_d;
  logic             up;
  logic             carry;
  logic             run;
  logic             at_end;
  logic             term;

`ifdef SYNUCNT_DIR_EN
  assign up = dnl;
`else
  assign up = 1'b1;
`endif

  // Toggle chain: bit n flips when ci and all lower bits are ones (up) or zeros (down).
  always_comb begin
    carry  = ci;
    q_step = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      q_step[i] = q_q[i] ^ carry;
      carry     = carry & (up ? q_q[i] : ~q_q[i]);
    end
  end

  assign run    = (state_q == StRun);
  assign at_end = up ? (&q_q) : (q_q == '0);
  assign term   = run & ci & (q_q == cmp);
  assign reload = up ? '0 : d;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tc_d    = 1'b0;
    if (!cll) begin
      q_d     = '0;
      state_d = StIdle;
    end else if (!ldl) begin
      // Load beats counting and a coincident terminal event; state is kept.
      q_d = d;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (go) state_d = StRun;
        end
        StRun: begin
          if (term) begin
            tc_d = 1'b1;
            if (period) q_d = reload;
            else        state_d = StDone;
          end else if (ci) begin
            q_d = q_step;
          end
        end
        StDone: begin
          if (go) begin
            state_d = StRun;
            q_d     = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= StIdle;
      q_q     <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
    end
  end

  assign q    = q_q;
  assign qb   = ~q_q;
  assign co   = ci & at_end & run;
  assign tc   = tc_q;
  assign busy = run;

endmodule

// File: tb/tb_syn_ucnt_timer.sv
// Directed self-checking bench for syn_ucnt_timer (WIDTH=8), immediate-assertion style.
module tb_syn_ucnt_timer;

  logic       clk = 1'b0;
  logic       resetl, cll, ldl, go, ci, period;
  logic [7:0] d, cmp;
  logic [7:0] q, qb;
  logic       co, tc, busy;
`ifdef SYNUCNT_DIR_EN
  logic       dnl = 1'b1;
`endif

  int vectors = 0;
  int miscompares = 0;
  int pulses;

  always #5 clk = ~clk;

  syn_ucnt_timer #(.WIDTH(8)) dut (
    .clk    (clk),
    .resetl (resetl),
    .cll    (cll),
    .ldl    (ldl),
    .d      (d),
    .cmp    (cmp),
    .go     (go),
    .ci     (ci),
    .period (period),
`ifdef SYNUCNT_DIR_EN
    .dnl    (dnl),
`endif
    .q      (q),
    .qb     (qb),
    .co     (co),
    .tc     (tc),
    .busy   (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are changed and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetl = 1'b0; cll = 1'b1; ldl = 1'b1; go = 1'b0; ci = 1'b0; period = 1'b0;
    d = 8'h00; cmp = 8'h00;
    #1;
    chk("rst_q", q, 8'h00);
    chk("rst_qb", qb, 8'hFF);
    chk("rst_tc", tc, 0);
    chk("rst_busy", busy, 0);
    #1 resetl = 1'b1;

    // One-shot to CMP=5
    cmp = 8'd5; period = 1'b0; go = 1'b1; ci = 1'b1;
    tick();
    chk("os_start_q", q, 0);
    chk("os_start_busy", busy, 1);
    go = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("os_q", q, k);
      chk("os_tc_low", tc, 0);
    end
    tick();
    chk("os_done_q", q, 5);
    chk("os_done_busy", busy, 0);
    chk("os_done_tc", tc, 1);
    tick();
    chk("os_tc_one_cycle", tc, 0);
    chk("os_hold_q", q, 5);

    // GO from DONE restarts at 0, then CI gating
    go = 1'b1; ci = 1'b0; cmp = 8'h80;
    tick();
    chk("restart_q", q, 0);
    chk("restart_busy", busy, 1);
    go = 1'b0;
    ci = 1'b1; tick(); chk("ci1_a", q, 1);
    ci = 1'b0; tick(); chk("ci0_a", q, 1);
    ci = 1'b1; tick(); chk("ci1_b", q, 2);
    ci = 1'b0; tick(); chk("ci0_b", q, 2);
    chk("ci0_tc", tc, 0);
    go = 1'b1; tick(); go = 1'b0;
    chk("go_in_run_q", q, 2);
    chk("go_in_run_busy", busy, 1);

    // Clear beats load
    cll = 1'b0; ldl = 1'b0; d = 8'h33;
    tick();
    cll = 1'b1; ldl = 1'b1;
    chk("clr_q", q, 0);
    chk("clr_busy", busy, 0);

    // Periodic CMP=3: 0,1,2,3 then reload; TC after edges 4, 8, 12
    cmp = 8'd3; period = 1'b1; go = 1'b1; ci = 1'b0;
    tick();
    go = 1'b0; ci = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("per_q", q, i % 4);
      chk("per_tc", tc, (i % 4 == 0) ? 1 : 0);
      if (tc) pulses++;
    end
    chk("per_pulses", pulses, 3);

    // Periodic CMP=0: Q stays 0, TC every CI cycle
    cmp = 8'd0;
    tick(); tick();
    chk("cmp0_q", q, 0);
    chk("cmp0_tc", tc, 1);
    ci = 1'b0; tick();
    chk("cmp0_ci0_tc", tc, 0);
    ci = 1'b1;

    // Load coinciding with terminal event: load wins, no TC
    ldl = 1'b0; d = 8'h44;
    tick();
    ldl = 1'b1;
    chk("ld_term_q", q, 8'h44);
    chk("ld_term_tc", tc, 0);
    chk("ld_term_busy", busy, 1);

    // Load FE, run through wrap
    cll = 1'b0; tick(); cll = 1'b1;
    ldl = 1'b0; d = 8'hFE; ci = 1'b0;
    tick();
    ldl = 1'b1;
    chk("ld_q", q, 8'hFE);
    chk("ld_idle_busy", busy, 0);
    cmp = 8'h10; period = 1'b0; go = 1'b1;
    tick();
    go = 1'b0; ci = 1'b1;
    chk("wrap_fe", q, 8'hFE);
    chk("wrap_fe_co", co, 0);
    tick();
    chk("wrap_ff", q, 8'hFF);
    chk("wrap_ff_qb", qb, 8'h00);
    chk("wrap_ff_co", co, 1);
    tick();
    chk("wrap_00", q, 8'h00);
    chk("wrap_00_co", co, 0);
    tick();
    chk("wrap_01", q, 8'h01);

    // Asynchronous reset mid-count at 0x5A
    ldl = 1'b0; d = 8'h5A;
    tick();
    ldl = 1'b1;
    chk("pre_rst_q", q, 8'h5A);
    #2 resetl = 1'b0;
    #1;
    chk("async_q", q, 8'h00);
    chk("async_qb", qb, 8'hFF);
    chk("async_busy", busy, 0);
    chk("async_tc", tc, 0);
    tick();
    chk("async_hold_q", q, 8'h00);
    resetl = 1'b1; ci = 1'b0;

`ifdef SYNUCNT_DIR_EN
    // Down count from 2 with borrow on 0->FF
    ldl = 1'b0; d = 8'h02; tick(); ldl = 1'b1;
    cmp = 8'h80; period = 1'b0; go = 1'b1; tick(); go = 1'b0;
    dnl = 1'b0; ci = 1'b1;
    tick(); chk("dn_1", q, 8'h01);
    tick(); chk("dn_0", q, 8'h00);
    chk("dn_borrow", co, 1);
    tick(); chk("dn_ff", q, 8'hFF);
    chk("dn_ff_co", co, 0);
    ci = 1'b0; dnl = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
